// File: rtl/iq_stream_tx.sv
// IQ result streamer: buffers signed I/Q results and emits them as five 16-bit lanes.
// Frame layout: lane0 = header, lane1/2 = I high/low half, lane3/4 = Q high/low half.
// Optional feature macro: IQ_STREAM_TX_SEQ_EN adds a 12-bit frame sequence number to the header.
module iq_stream_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic        iq_valid,
    input  logic [31:0] i_val,
    input  logic [31:0] q_val,
    output logic [15:0] data_out_0,
    output logic [15:0] data_out_1,
    output logic [15:0] data_out_2,
    output logic [15:0] data_out_3,
    output logic [15:0] data_out_4,
    output logic        data_out_valid,
    output logic        overflow,
    output logic [4:0]  fifo_level
);

    localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L  = 5'(FIFO_DEPTH);
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} TxState;

    TxState        state;
    TxState        nextState;
    logic [63:0]   fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [4:0]    level;
    logic [7:0]    gapCount;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          push;
    logic          pop;
    logic [63:0]   popData;

    // A full buffer still takes a push when the same cycle frees an entry; flush blocks both.
    assign fifoEmpty  = (level == 5'd0);
    assign fifoFull   = (level == DEPTH_L);
    assign pop        = (state == IDLE) && enable && !fifoEmpty && !flush;
    assign push       = iq_valid && !flush && (!fifoFull || pop);
    assign popData    = fifoMem[rdPtr];
    assign fifo_level = level;

    // Result storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push)
            fifoMem[wrPtr] <= {i_val, q_val};
    end

    // Buffer pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wrPtr <= wrPtr + AW'(1);
            if (pop)
                rdPtr <= rdPtr + AW'(1);
            if (push && !pop)
                level <= level + 5'd1;
            else if (pop && !push)
                level <= level - 5'd1;
            if (iq_valid && fifoFull && !pop)
                overflow <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic; a SEND cycle is never cut short, flush only skips the gap.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (pop) nextState = SEND;
            SEND: begin
                if (flush || GAP_CYCLES == 0)
                    nextState = IDLE;
                else
                    nextState = GAP;
            end
            GAP:  if (flush || gapCount == GAP_LAST) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic: lanes are registered, so only the valid strobe is decoded here.
    always_comb begin
        data_out_valid = (state == SEND);
    end

    // Counts idle cycles spent in GAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            gapCount <= '0;
        else if (state == GAP)
            gapCount <= gapCount + 8'd1;
        else
            gapCount <= '0;
    end

    // Payload lanes load on pop and hold their value otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_1 <= '0;
            data_out_2 <= '0;
            data_out_3 <= '0;
            data_out_4 <= '0;
        end else if (pop) begin
            data_out_1 <= popData[63:48];
            data_out_2 <= popData[47:32];
            data_out_3 <= popData[31:16];
            data_out_4 <= popData[15:0];
        end
    end

`ifdef IQ_STREAM_TX_SEQ_EN
    logic [11:0] seqCount;

    // Header carries the sequence number of the frame being sent; wraps naturally at 12 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seqCount   <= '0;
            data_out_0 <= '0;
        end else if (flush) begin
            seqCount   <= '0;
        end else if (pop) begin
            data_out_0 <= {4'hA, seqCount};
            seqCount   <= seqCount + 12'd1;
        end
    end
`else
    // Fixed header; it still clears in reset so that every lane reads zero there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            data_out_0 <= '0;
        else if (pop)
            data_out_0 <= 16'hA000;
    end
`endif

endmodule

// File: tb/tb_iq_stream_tx.sv
// Self-checking bench for iq_stream_tx: one instance with no gap, one with a 3-cycle gap.
// Frames from the no-gap instance are compared against a scoreboard of pushed results.
module tb_iq_stream_tx;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] q;
    } IqPair;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        iqValid = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] iVal = '0;
    logic [31:0] qVal = '0;
    logic        iqValid0;
    logic        iqValid3;

    logic [15:0] dataOut0, dataOut1, dataOut2, dataOut3, dataOut4;
    logic        dataOutValid0, overflow0;
    logic [4:0]  fifoLevel0;
    logic [15:0] gOut0, gOut1, gOut2, gOut3, gOut4;
    logic        dataOutValid3, overflow3;
    logic [4:0]  fifoLevel3;

    int          checks = 0;
    int          errors = 0;
    int          frameCount = 0;
    logic [11:0] expSeq = '0;
    logic [15:0] lastHeader = '0;
    IqPair       sbQ[$];

    assign iqValid0 = iqValid && !sel;
    assign iqValid3 = iqValid && sel;

    always #5 clk = ~clk;

    iq_stream_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .iq_valid(iqValid0), .i_val(iVal), .q_val(qVal),
        .data_out_0(dataOut0), .data_out_1(dataOut1), .data_out_2(dataOut2),
        .data_out_3(dataOut3), .data_out_4(dataOut4),
        .data_out_valid(dataOutValid0), .overflow(overflow0), .fifo_level(fifoLevel0)
    );

    iq_stream_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .iq_valid(iqValid3), .i_val(iVal), .q_val(qVal),
        .data_out_0(gOut0), .data_out_1(gOut1), .data_out_2(gOut2),
        .data_out_3(gOut3), .data_out_4(gOut4),
        .data_out_valid(dataOutValid3), .overflow(overflow3), .fifo_level(fifoLevel3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Drives one result at the falling edge; optionally records it as an expected frame.
    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] q, input bit track);
        @(negedge clk);
        iqValid = 1'b1;
        iVal    = i;
        qVal    = q;
        if (track)
            sbQ.push_back('{i: i, q: q});
    endtask

    // Scoreboard monitor: every valid frame from the no-gap instance must match the oldest entry.
    always @(negedge clk) begin
        IqPair       expPair;
        logic [15:0] expHdr;
        if (rst && dataOutValid0) begin
            checks++;
            assert (sbQ.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpectedFrame: observed frame with header %h expected no frame", dataOut0);
            end
            if (sbQ.size() != 0) begin
                expPair = sbQ.pop_front();
`ifdef IQ_STREAM_TX_SEQ_EN
                expHdr = {4'hA, expSeq};
`else
                expHdr = 16'hA000;
`endif
                checkOutput("lane0", 32'(dataOut0), 32'(expHdr));
                checkOutput("lane1", 32'(dataOut1), 32'(expPair.i[31:16]));
                checkOutput("lane2", 32'(dataOut2), 32'(expPair.i[15:0]));
                checkOutput("lane3", 32'(dataOut3), 32'(expPair.q[31:16]));
                checkOutput("lane4", 32'(dataOut4), 32'(expPair.q[15:0]));
                lastHeader = dataOut0;
                expSeq     = expSeq + 12'd1;
                frameCount++;
            end
        end
    end

    initial begin
        bit [0:9]  altPat = 10'b1010101000;
        bit [0:13] gapPat = 14'b10000100001000;
        int        fcStart;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstValid", 32'(dataOutValid0), 32'd0);
        checkOutput("rstLevel", 32'(fifoLevel0), 32'd0);
        checkOutput("rstOverflow", 32'(overflow0), 32'd0);
        checkOutput("rstLane0", 32'(dataOut0), 32'd0);
        checkOutput("rstLane1", 32'(dataOut1), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single result latency: valid only in cycle 2
        enable = 1'b1;
        applyStimulus(32'h12345678, 32'hFEDCBA98, 1'b1);
        @(negedge clk);
        iqValid = 1'b0;
        checkOutput("latCycle1Valid", 32'(dataOutValid0), 32'd0);
        checkOutput("latCycle1Level", 32'(fifoLevel0), 32'd1);
        @(negedge clk);
        checkOutput("latCycle2Valid", 32'(dataOutValid0), 32'd1);
        checkOutput("latCycle2Level", 32'(fifoLevel0), 32'd0);
        @(negedge clk);
        checkOutput("latCycle3Valid", 32'(dataOutValid0), 32'd0);

        // Overflow: six pushes into depth four while disabled, then back-to-back drain
        enable = 1'b0;
        for (int k = 0; k < 6; k++)
            applyStimulus(32'h1000_0000 + 32'(k), 32'h2000_0000 - 32'(k), k < 4);
        @(negedge clk);
        iqValid = 1'b0;
        checkOutput("ovfLevel", 32'(fifoLevel0), 32'd4);
        checkOutput("ovfFlag", 32'(overflow0), 32'd1);
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("altValid%0d", k), 32'(dataOutValid0), 32'(altPat[k]));
        end
        checkOutput("ovfSticky", 32'(overflow0), 32'd1);
        checkOutput("altDrained", 32'(sbQ.size()), 32'd0);

        // Flush clears overflow and the sequence counter
        @(negedge clk);
        enable = 1'b0;
        flush  = 1'b1;
        expSeq = '0;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flushOverflow", 32'(overflow0), 32'd0);
        checkOutput("flushLevel", 32'(fifoLevel0), 32'd0);

        // Full buffer with push coincident with pop
        for (int k = 0; k < 4; k++)
            applyStimulus(32'hA5A5_0000 + 32'(k), 32'h5A5A_0000 + 32'(k), 1'b1);
        applyStimulus(32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        iqValid = 1'b0;
        checkOutput("fullPushPopLevel", 32'(fifoLevel0), 32'd4);
        checkOutput("fullPushPopOverflow", 32'(overflow0), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("fullDrained", 32'(sbQ.size()), 32'd0);
        checkOutput("fullDrainedLevel", 32'(fifoLevel0), 32'd0);

        // Flush with three queued results: nothing is sent afterwards
        enable = 1'b0;
        for (int k = 0; k < 3; k++)
            applyStimulus(32'h7777_0000 + 32'(k), 32'h8888_0000 + 32'(k), 1'b0);
        @(negedge clk);
        iqValid = 1'b0;
        flush   = 1'b1;
        expSeq  = '0;
        @(negedge clk);
        flush  = 1'b0;
        enable = 1'b1;
        checkOutput("flush3Level", 32'(fifoLevel0), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("flush3Valid%0d", k), 32'(dataOutValid0), 32'd0);
        end

        // Reset asserted mid-backlog
        enable = 1'b0;
        for (int k = 0; k < 3; k++)
            applyStimulus(32'h3141_5926 + 32'(k), 32'h2718_2818 + 32'(k), 1'b1);
        @(negedge clk);
        iqValid = 1'b0;
        enable  = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        sbQ.delete();
        expSeq = '0;
        @(negedge clk);
        checkOutput("midRstValid", 32'(dataOutValid0), 32'd0);
        checkOutput("midRstLevel", 32'(fifoLevel0), 32'd0);
        checkOutput("midRstOverflow", 32'(overflow0), 32'd0);
        checkOutput("midRstLanes", {dataOut1, dataOut2}, 32'd0);
        checkOutput("midRstLanesQ", {dataOut3, dataOut4}, 32'd0);
        checkOutput("midRstLane0", 32'(dataOut0), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Gap instance: three queued results with a 3-cycle gap
        sel    = 1'b1;
        enable = 1'b0;
        for (int k = 0; k < 3; k++)
            applyStimulus(32'h0BAD_0000 + 32'(k), 32'h0DAD_0000 + 32'(k), 1'b0);
        @(negedge clk);
        iqValid = 1'b0;
        enable  = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            checkOutput($sformatf("gapValid%0d", k), 32'(dataOutValid3), 32'(gapPat[k]));
        end
        checkOutput("gapLevel", 32'(fifoLevel3), 32'd0);
        sel = 1'b0;

        // Sequence wrap: 4097 frames, the last one carries sequence 0 again
        fcStart = frameCount;
        for (int k = 0; k < 4097; k++) begin
            applyStimulus($urandom, $urandom, 1'b1);
            @(negedge clk);
            iqValid = 1'b0;
        end
        repeat (4) @(negedge clk);
        checkOutput("wrapFrames", 32'(frameCount - fcStart), 32'd4097);
        checkOutput("wrapHeader", 32'(lastHeader), 32'h0000A000);
        checkOutput("wrapDrained", 32'(sbQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_stream_tx.md
IQ_STREAM_TX -- requirements
Module: iq_stream_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the result buffer depth in entries (power of two, 2..16).
REQ-002 Parameter GAP_CYCLES, default 0, SHALL set the minimum idle cycles inserted after each transmitted frame (0..255).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, SHALL be the single system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port enable, input, 1, SHALL permit frame transmission when high.
REQ-007 Port flush, input, 1, SHALL synchronously empty the buffer, clear overflow and zero the sequence counter.
REQ-008 Port iq_valid, input, 1, SHALL qualify i_val and q_val for one cycle per result.
REQ-009 Ports i_val and q_val, input, 32 each, SHALL carry the signed demodulated I and Q results.
REQ-010 Ports data_out_0..data_out_4, output, 16 each, SHALL carry the five FCx5 stream lanes.
REQ-011 Port data_out_valid, output, 1, SHALL qualify all five lanes.
REQ-012 Port overflow, output, 1, SHALL be a sticky flag set on a dropped result.
REQ-013 Port fifo_level, output, 5, SHALL report current buffer occupancy.

Function
REQ-014 A result SHALL be pushed on every cycle with iq_valid=1, except when full without a same-cycle pop; it is then dropped and overflow set.
REQ-015 Push and pop in the same cycle on a full buffer SHALL accept the push; level unchanged.
REQ-016 FSM states SHALL be IDLE, SEND, GAP; only IDLE pops.
REQ-017 IDLE->SEND when enable=1 and buffer non-empty: pop one entry and register it into the lanes.
REQ-018 SEND SHALL last exactly one cycle with data_out_valid=1, then go to GAP if GAP_CYCLES>0, else IDLE.
REQ-019 GAP SHALL hold data_out_valid=0 for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-020 With GAP_CYCLES=0 and a backlog, valid SHALL alternate 1,0 (one IDLE pop cycle between frames).
REQ-021 Lane mapping: data_out_1=i[31:16], data_out_2=i[15:0], data_out_3=q[31:16], data_out_4=q[15:0]; data_out_0 per REQ-028.
REQ-022 Latency: iq_valid in cycle 0 into an empty buffer, state IDLE, enable=1 -> data_out_valid=1 in cycle 2 only.
REQ-023 enable falling during SEND or GAP SHALL let that frame and its gap complete; no further pops.
REQ-024 Outside SEND, lanes SHALL hold their last values; data_out_valid=0.
REQ-025 flush SHALL take priority over same-cycle push and pop, forcing IDLE; a SEND in progress still completes its valid cycle.
REQ-026 The 12-bit sequence counter SHALL increment per transmitted frame and wrap 4095->0.

Reset
REQ-027 While rst=0: state IDLE, buffer empty, fifo_level=0, overflow=0, sequence=0, data_out_valid=0, all lanes 0x0000; a frame in progress is abandoned with no partial output.

Configuration
REQ-028 Macro IQ_STREAM_TX_SEQ_EN defined: data_out_0={4'hA, seq[11:0]}; undefined: data_out_0=16'hA000, counter not implemented.

Verification
REQ-029 Single result I=0x12345678, Q=0xFEDCBA98, GAP=0 -> one valid cycle in cycle 2, lanes A000/1234/5678/FEDC/BA98 (seq 0 with macro).
REQ-030 enable=0, push 6 results into depth 4 -> fifo_level=4, overflow=1; enable=1 -> exactly 4 frames, first four data, in order.
REQ-031 GAP_CYCLES=3, 3 queued results -> valid pattern 1,0,0,0,0,1,0,0,0,0,1.
REQ-032 Macro defined, 4097 frames -> header of frame 4096 = 0xA000 (wrap).
REQ-033 Full buffer, push coincident with pop -> push accepted, overflow stays 0.
REQ-034 rst low mid-backlog -> all outputs 0 next cycle; flush with 3 queued -> fifo_level=0, no further frames.
